data_mem_byte: RTL and testbench
================================

DATA_MEM_BYTE -- requirements
Module: data_mem_byte

Interface
REQ-001 Parameter ADDR_W, default 8, SHALL set word-address width; depth = 2^ADDR_W 32-bit words.
REQ-002 Parameter WAIT_STATES, default 1, range 0..15, SHALL set extra cycles inserted before completion.
REQ-003 Port clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 Port req  input  1  SHALL request an access; sampled only in IDLE.
REQ-006 Port we  input  1  SHALL select store (1) or load (0).
REQ-007 Port size  input  2  SHALL select access width: 00 byte, 01 half, 10 word; 11 is illegal.
REQ-008 Port load_unsigned  input  1  SHALL select zero-extension (1) or sign-extension (0) for byte/half loads.
REQ-009 Port addr  input  32  SHALL carry the byte address.
REQ-010 Port wdata  input  32  SHALL carry store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-011 Port busy  output  1  SHALL be high in any state other than IDLE.
REQ-012 Port ack  output  1  SHALL pulse high for exactly one cycle when an access completes.
REQ-013 Port rdata  output  32  SHALL carry the extended load result.
REQ-014 Port err  output  1  SHALL flag a misaligned or illegal-size access, valid with ack.

Function
REQ-015 FSM states SHALL be IDLE, WAIT, DONE.
REQ-016 In IDLE with req=1, the block SHALL latch addr, we, size, load_unsigned and wdata, then go to WAIT if WAIT_STATES>0, else to DONE.
REQ-017 In WAIT, a down-counter loaded with WAIT_STATES-1 SHALL decrement each cycle; at 0 the FSM SHALL go to DONE.
REQ-018 In DONE, ack SHALL be 1 for that cycle and the FSM SHALL return to IDLE on the next edge.
REQ-019 Latency from the req-sampling edge to ack high SHALL be WAIT_STATES+1 cycles; back-to-back throughput SHALL be one access per WAIT_STATES+2 cycles.
REQ-020 req and all request inputs SHALL be ignored while busy=1; they need not be held stable.
REQ-021 Word index SHALL be addr[ADDR_W+1:2]; higher address bits SHALL be ignored (aliasing and wrap-around).
REQ-022 Lanes SHALL be little-endian: byte offset k = addr[1:0] maps to bits [8k+7:8k].
REQ-023 Alignment: half requires addr[0]=0; word requires addr[1:0]=00.
REQ-024 A misaligned or size=11 access SHALL set err=1 with ack, SHALL leave memory unchanged, and SHALL return rdata=0.
REQ-025 A store SHALL write only the addressed lanes, on the DONE-cycle edge; other lanes SHALL be preserved.
REQ-026 A load SHALL read the word combinationally in DONE. The selected byte or half SHALL be extended per load_unsigned and registered into rdata together with ack.
REQ-027 rdata SHALL hold its last value until the next completed load or error; stores SHALL not alter rdata.
REQ-028 err SHALL be 0 on every successful completion.
REQ-029 Memory contents SHALL initialise to zero at time zero and SHALL not be cleared by reset.

Reset
REQ-030 rst_n low SHALL immediately force IDLE, busy=0, ack=0, err=0, rdata=0 and counter=0.
REQ-031 Reset asserted mid-access (WAIT or DONE before the edge) SHALL abort the access with no memory write.
REQ-032 The first req SHALL be sampled on the first rising edge with rst_n high.

Verification
REQ-033 WAIT_STATES=1: store word 0x12345678 to addr 0x10, then load word from 0x10 -> ack 2 cycles after req, rdata=0x12345678, err=0.
REQ-034 Store byte 0xAB to 0x11 over 0x12345678, then load word 0x10 -> 0x1234AB78; load byte signed 0x11 -> 0xFFFFFFAB; load byte unsigned -> 0x000000AB.
REQ-035 Store half 0x8001 to 0x12, then load half signed 0x12 -> 0xFFFF8001; load half unsigned -> 0x00008001.
REQ-036 Load half at 0x13, store word at 0x02 and size=11 -> err=1 with ack, rdata=0, memory unchanged.
REQ-037 ADDR_W=8: store word 0xCAFEF00D to 0x400, then load word from 0x000 -> 0xCAFEF00D (wrap-around).
REQ-038 WAIT_STATES=3: assert rst_n=0 two cycles into a store of 0xFFFFFFFF to 0x20 -> busy and ack drop at once; a later load from 0x20 returns its prior value.

Source files
------------

// File: rtl/data_mem_byte.sv
// Byte-addressable 32-bit data memory with configurable wait states, little-endian
// lane selection, load sign/zero extension and misalignment/illegal-size error reporting.
`timescale 1ns/1ps
module data_mem_byte #(
    parameter int ADDR_W      = 8,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        load_unsigned,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        ack,
    output logic [31:0] rdata,
    output logic        err
);

    localparam int         DEPTH    = 1 << ADDR_W;
    localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    logic [3:0]        cnt;

    logic [ADDR_W+1:0] addr_p0;
    logic              we_p0;
    logic [1:0]        size_p0;
    logic              uns_p0;
    logic [31:0]       wdata_p0;

    logic [31:0]       mem [DEPTH];

    logic [ADDR_W-1:0] word_idx;
    logic [1:0]        ofs;
    logic              bad;
    logic [31:0]       rd_word;
    logic [31:0]       rd_lane;
    logic [31:0]       wr_data;
    logic [3:0]        be;

    // Address bits above the word index alias onto the same storage.
    logic              unused_addr_bits;
    assign unused_addr_bits = ^addr[31:ADDR_W+2];

    function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] o);
        case (sz)
            2'b00:   return 1'b0;
            2'b01:   return o[0];
            2'b10:   return (o != 2'b00);
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] extend(input logic [31:0] v, input logic [1:0] sz,
                                           input logic uns);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        b = v[7:0];
        h = v[15:0];
        case (sz)
            2'b00:   return uns ? {24'd0, v[7:0]}  : 32'(b);
            2'b01:   return uns ? {16'd0, v[15:0]} : 32'(h);
            default: return v;
        endcase
    endfunction

    function automatic logic [3:0] lanes(input logic [1:0] sz, input logic [1:0] o);
        case (sz)
            2'b00:   return 4'b0001 << o;
            2'b01:   return 4'b0011 << o;
            default: return 4'b1111;
        endcase
    endfunction

    // Stage p0: request fields captured when the FSM accepts a request.
    always_ff @(posedge clk) begin
        if (state == IDLE && req) begin
            addr_p0  <= addr[ADDR_W+1:0];
            we_p0    <= we;
            size_p0  <= size;
            uns_p0   <= load_unsigned;
            wdata_p0 <= wdata;
        end
    end

    assign word_idx = addr_p0[ADDR_W+1:2];
    assign ofs      = addr_p0[1:0];
    assign bad      = misaligned(size_p0, ofs);
    assign rd_word  = mem[word_idx];
    assign rd_lane  = rd_word >> {ofs, 3'b000};
    assign wr_data  = wdata_p0 << {ofs, 3'b000};
    assign be       = lanes(size_p0, ofs);

    // Stage p1: lane-masked store commits on the edge that leaves DONE.
    always_ff @(posedge clk) begin
        if (state == DONE && we_p0 && !bad) begin
            for (int k = 0; k < 4; k++) begin
                if (be[k]) mem[word_idx][8*k +: 8] <= wr_data[8*k +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= 4'd0;
            busy  <= 1'b0;
            ack   <= 1'b0;
            err   <= 1'b0;
            rdata <= '0;
        end else begin
            ack <= 1'b0;
            err <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        busy <= 1'b1;
                        cnt  <= CNT_INIT;
                        if (WAIT_STATES > 0) state <= WAIT;
                        else                 state <= DONE;
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) state <= DONE;
                    else             cnt   <= cnt - 4'd1;
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    ack   <= 1'b1;
                    err   <= bad;
                    if (bad)         rdata <= '0;
                    else if (!we_p0) rdata <= extend(rd_lane, size_p0, uns_p0);
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_byte.sv
// Randomized and directed bench for data_mem_byte against a byte-array reference model,
// using one instance with one wait state and one with three.
`timescale 1ns/1ps
module tb_data_mem_byte;

    localparam int ADDR_W = 8;
    localparam int NBYTES = 4 * (1 << ADDR_W);

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, req1, req3, we, load_unsigned;
    logic [1:0]  size;
    logic [31:0] addr, wdata;
    logic        busy1, ack1, err1, busy3, ack3, err3;
    logic [31:0] rdata1, rdata3;

    int          sel;
    logic        cur_busy, cur_ack, cur_err;
    logic [31:0] cur_rdata;
    assign cur_busy  = (sel == 0) ? busy1  : busy3;
    assign cur_ack   = (sel == 0) ? ack1   : ack3;
    assign cur_err   = (sel == 0) ? err1   : err3;
    assign cur_rdata = (sel == 0) ? rdata1 : rdata3;

    int          n_checks = 0;
    int          n_fail   = 0;

    logic [7:0]  mb [2][NBYTES];
    logic [31:0] last_rd [2];

    data_mem_byte #(.ADDR_W(ADDR_W), .WAIT_STATES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .req(req1), .we(we), .size(size),
        .load_unsigned(load_unsigned), .addr(addr), .wdata(wdata),
        .busy(busy1), .ack(ack1), .rdata(rdata1), .err(err1)
    );

    data_mem_byte #(.ADDR_W(ADDR_W), .WAIT_STATES(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .req(req3), .we(we), .size(size),
        .load_unsigned(load_unsigned), .addr(addr), .wdata(wdata),
        .busy(busy3), .ack(ack3), .rdata(rdata3), .err(err3)
    );

    // Reference: memory as a flat byte array; loads assemble bytes and extend arithmetically.
    function automatic void model_access(input int d, input bit w, input logic [1:0] sz,
                                         input bit uns, input logic [31:0] a,
                                         input logic [31:0] wd, output logic [31:0] exp_rd,
                                         output bit exp_err);
        int         n;
        int         base;
        logic [63:0] v;
        n       = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        base    = int'(a % 32'(NBYTES));
        exp_err = (sz == 2'b11) || ((a % 32'(n)) != 0);
        if (exp_err) begin
            last_rd[d] = 32'd0;
        end else if (w) begin
            for (int i = 0; i < n; i++) mb[d][base + i] = wd[8*i +: 8];
        end else begin
            v = 64'd0;
            for (int i = 0; i < n; i++) v = v | (64'(mb[d][base + i]) << (8 * i));
            if (!uns && n < 4 && v[8*n - 1]) v = v | ~((64'd1 << (8 * n)) - 64'd1);
            last_rd[d] = v[31:0];
        end
        exp_rd = last_rd[d];
    endfunction

    task automatic do_access(input int d, input bit w, input logic [1:0] sz, input bit uns,
                             input logic [31:0] a, input logic [31:0] wd, input string tag,
                             output logic [31:0] rd_o, output logic err_o);
        logic [31:0] exp_rd;
        bit          exp_err;
        int          exp_lat;
        int          lat;
        model_access(d, w, sz, uns, a, wd, exp_rd, exp_err);
        exp_lat = (d == 0) ? 2 : 4;
        sel = d; we = w; size = sz; load_unsigned = uns; addr = a; wdata = wd;
        if (d == 0) req1 = 1'b1;
        else        req3 = 1'b1;
        @(posedge clk); #1;
        req1 = 1'b0; req3 = 1'b0;
        we = 1'($urandom); size = 2'($urandom); load_unsigned = 1'($urandom);
        addr = $urandom; wdata = $urandom;
        n_checks++;
        if (cur_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL %s busy: got %b want 1", tag, cur_busy);
        end
        lat = 0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (cur_ack === 1'b1) begin
                lat = c;
                break;
            end
        end
        rd_o  = cur_rdata;
        err_o = cur_err;
        n_checks++;
        if (lat != exp_lat) begin
            n_fail++;
            $display("FAIL %s latency: got %0d want %0d (0 = no ack)", tag, lat, exp_lat);
        end
        n_checks++;
        if (cur_rdata !== exp_rd) begin
            n_fail++;
            $display("FAIL %s rdata: got %h want %h (addr %h size %0d we %0b)", tag, cur_rdata,
                     exp_rd, a, sz, w);
        end
        n_checks++;
        if (cur_err !== 1'(exp_err)) begin
            n_fail++;
            $display("FAIL %s err: got %b want %b (addr %h size %0d)", tag, cur_err, exp_err, a, sz);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({busy1, ack1, err1, rdata1} !== 35'd0) begin
            n_fail++;
            $display("FAIL reset_dut1: got busy=%b ack=%b err=%b rdata=%h want all 0",
                     busy1, ack1, err1, rdata1);
        end
        n_checks++;
        if ({busy3, ack3, err3, rdata3} !== 35'd0) begin
            n_fail++;
            $display("FAIL reset_dut3: got busy=%b ack=%b err=%b rdata=%h want all 0",
                     busy3, ack3, err3, rdata3);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [31:0] rd;
        logic        er;
        do_access(0, 1, 2'b10, 0, 32'h10, 32'h12345678, "st_w", rd, er);
        do_access(0, 0, 2'b10, 0, 32'h10, 32'h0, "ld_w", rd, er);
        n_checks++;
        if (rd !== 32'h12345678) begin n_fail++; $display("FAIL ld_w_const: got %h want 12345678", rd); end
        do_access(0, 1, 2'b00, 0, 32'h11, 32'h555555AB, "st_b", rd, er);
        n_checks++;
        if (rd !== 32'h12345678) begin n_fail++; $display("FAIL st_keeps_rdata: got %h want 12345678", rd); end
        do_access(0, 0, 2'b10, 0, 32'h10, 32'h0, "ld_w2", rd, er);
        n_checks++;
        if (rd !== 32'h1234AB78) begin n_fail++; $display("FAIL ld_w2_const: got %h want 1234ab78", rd); end
        do_access(0, 0, 2'b00, 0, 32'h11, 32'h0, "ld_bs", rd, er);
        n_checks++;
        if (rd !== 32'hFFFFFFAB) begin n_fail++; $display("FAIL ld_bs_const: got %h want ffffffab", rd); end
        do_access(0, 0, 2'b00, 1, 32'h11, 32'h0, "ld_bu", rd, er);
        n_checks++;
        if (rd !== 32'h000000AB) begin n_fail++; $display("FAIL ld_bu_const: got %h want 000000ab", rd); end
        do_access(0, 1, 2'b01, 0, 32'h12, 32'h77778001, "st_h", rd, er);
        do_access(0, 0, 2'b01, 0, 32'h12, 32'h0, "ld_hs", rd, er);
        n_checks++;
        if (rd !== 32'hFFFF8001) begin n_fail++; $display("FAIL ld_hs_const: got %h want ffff8001", rd); end
        do_access(0, 0, 2'b01, 1, 32'h12, 32'h0, "ld_hu", rd, er);
        n_checks++;
        if (rd !== 32'h00008001) begin n_fail++; $display("FAIL ld_hu_const: got %h want 00008001", rd); end
        do_access(0, 0, 2'b01, 0, 32'h13, 32'h0, "ld_h_mis", rd, er);
        n_checks++;
        if (er !== 1'b1 || rd !== 32'd0) begin
            n_fail++; $display("FAIL ld_h_mis_const: got err=%b rdata=%h want err=1 rdata=0", er, rd);
        end
        do_access(0, 1, 2'b10, 0, 32'h02, 32'hDEADBEEF, "st_w_mis", rd, er);
        n_checks++;
        if (er !== 1'b1) begin n_fail++; $display("FAIL st_w_mis_const: got err=%b want 1", er); end
        do_access(0, 0, 2'b11, 0, 32'h10, 32'h0, "size11", rd, er);
        n_checks++;
        if (er !== 1'b1 || rd !== 32'd0) begin
            n_fail++; $display("FAIL size11_const: got err=%b rdata=%h want err=1 rdata=0", er, rd);
        end
        do_access(0, 0, 2'b10, 0, 32'h00, 32'h0, "ld_w0", rd, er);
        n_checks++;
        if (rd !== 32'd0) begin n_fail++; $display("FAIL ld_w0_const: got %h want 00000000", rd); end
        do_access(0, 0, 2'b10, 0, 32'h10, 32'h0, "ld_w3", rd, er);
        n_checks++;
        if (rd !== 32'h8001AB78) begin n_fail++; $display("FAIL ld_w3_const: got %h want 8001ab78", rd); end
        do_access(0, 1, 2'b10, 0, 32'h400, 32'hCAFEF00D, "st_wrap", rd, er);
        do_access(0, 0, 2'b10, 0, 32'h000, 32'h0, "ld_wrap", rd, er);
        n_checks++;
        if (rd !== 32'hCAFEF00D) begin n_fail++; $display("FAIL ld_wrap_const: got %h want cafef00d", rd); end
    endtask

    task automatic test_random(input int d, input int n);
        logic [31:0] rd;
        logic        er;
        logic [1:0]  sz;
        logic [31:0] a;
        for (int i = 0; i < n; i++) begin
            sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            a  = ($urandom & 32'hFFFF_FC00) | 32'($urandom_range(0, 63));
            do_access(d, 1'($urandom), sz, 1'($urandom), a, $urandom, "rand", rd, er);
        end
    endtask

    task automatic test_back_to_back();
        int          acks[$];
        logic [31:0] exp_rd;
        bit          exp_err;
        sel = 0; we = 1'b0; size = 2'b10; load_unsigned = 1'b0; addr = 32'h10; wdata = 32'h0;
        req1 = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            @(posedge clk); #1;
            if (ack1 === 1'b1) begin
                acks.push_back(c);
                model_access(0, 0, 2'b10, 0, 32'h10, 32'h0, exp_rd, exp_err);
                n_checks++;
                if (rdata1 !== exp_rd) begin
                    n_fail++; $display("FAIL b2b_rdata: got %h want %h", rdata1, exp_rd);
                end
            end
        end
        req1 = 1'b0;
        n_checks++;
        if (acks.size() != 3) begin
            n_fail++; $display("FAIL b2b_count: got %0d acks want 3", acks.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                n_checks++;
                if (acks[k] != 3 * (k + 1)) begin
                    n_fail++; $display("FAIL b2b_slot%0d: got cycle %0d want %0d", k, acks[k], 3 * (k + 1));
                end
            end
        end
        @(posedge clk); #1;
        n_checks++;
        if (busy1 !== 1'b0 || ack1 !== 1'b0) begin
            n_fail++; $display("FAIL b2b_idle: got busy=%b ack=%b want 0 0", busy1, ack1);
        end
    endtask

    task automatic test_reset_abort();
        logic [31:0] rd;
        logic        er;
        do_access(1, 1, 2'b10, 0, 32'h20, 32'h5A5A1234, "pre_st", rd, er);
        sel = 1; we = 1'b1; size = 2'b10; load_unsigned = 1'b0; addr = 32'h20; wdata = 32'hFFFFFFFF;
        req3 = 1'b1;
        @(posedge clk); #1;
        req3 = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        n_checks++;
        if (busy3 !== 1'b1) begin n_fail++; $display("FAIL abort_midbusy: got %b want 1", busy3); end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy3, ack3, err3, rdata3} !== 35'd0) begin
            n_fail++;
            $display("FAIL abort_async: got busy=%b ack=%b err=%b rdata=%h want all 0",
                     busy3, ack3, err3, rdata3);
        end
        n_checks++;
        if (rdata1 !== 32'd0) begin n_fail++; $display("FAIL abort_rdata1: got %h want 0", rdata1); end
        @(negedge clk);
        rst_n      = 1'b1;
        last_rd[0] = 32'd0;
        last_rd[1] = 32'd0;
        do_access(1, 0, 2'b10, 0, 32'h20, 32'h0, "post_abort_ld", rd, er);
        n_checks++;
        if (rd !== 32'h5A5A1234) begin
            n_fail++; $display("FAIL abort_nowrite: got %h want 5a5a1234", rd);
        end
    endtask

    initial begin
        foreach (mb[i, j]) mb[i][j] = 8'd0;
        last_rd[0] = 32'd0;
        last_rd[1] = 32'd0;
        rst_n = 1'b0; req1 = 1'b0; req3 = 1'b0; we = 1'b0; size = 2'b00;
        load_unsigned = 1'b0; addr = 32'd0; wdata = 32'd0; sel = 0;
        test_reset();
        test_directed();
        test_random(0, 150);
        test_back_to_back();
        test_random(1, 40);
        test_reset_abort();
        test_random(0, 30);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
